// File: rtl/dff_ureg.sv
// dff_ureg: universal shift register (hold / shift right / shift left / parallel load) with sync reset.
// Define DFF_UREG_ROTATE_EN to add the ROT input that turns shifts into rotates.
module dff_ureg #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       M,
  input  logic             SIR,
  input  logic             SIL,
`ifdef DFF_UREG_ROTATE_EN
  input  logic             ROT,
`endif
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] nQ,
  output logic             SO,
  output logic             Z
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic             in_r, in_l;
`ifdef DFF_UREG_ROTATE_EN
  assign in_r = ROT ? q_q[0] : SIR;
  assign in_l = ROT ? q_q[WIDTH-1] : SIL;
`else
  assign in_r = SIR;
  assign in_l = SIL;
`endif
  // Unknown mode values fall through to the hold default.
  always_comb begin
    q_d  = q_q;
    so_d = 1'b0;
    case (M)
      2'b01: begin
        q_d  = {in_r, q_q[WIDTH-1:1]};
        so_d = q_q[0];
      end
      2'b10: begin
        q_d  = {q_q[WIDTH-2:0], in_l};
        so_d = q_q[WIDTH-1];
      end
      2'b11: q_d = D;
      default: q_d = q_q;
    endcase
  end
  always_ff @(posedge C) begin
    if (R) begin
      q_q  <= INIT;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end
  assign Q  = q_q;
  assign nQ = ~q_q;
  assign SO = so_q;
  assign Z  = (q_q == '0);
endmodule

// File: tb/tb_dff_ureg.sv
// tb_dff_ureg: random + directed check of dff_ureg against an arithmetic model (two INIT values).
module tb_dff_ureg;
  localparam int W = 8;
  localparam logic [63:0] MASK = (64'd1 << W) - 1;
`ifdef DFF_UREG_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif
  logic C = 0, R = 0, SIR = 0, SIL = 0, rot = 0;
  logic [1:0] M = 0;
  logic [W-1:0] D = 0;
  logic [W-1:0] qa, nqa, qb, nqb;
  logic soa, za, sob, zb;
  logic [63:0] ma = 0, mb = 0;
  logic msa = 0, msb = 0;
  bit started = 0;
  int vectors = 0, errs = 0;

  dff_ureg #(.WIDTH(W), .INIT(8'h00)) dut_a (
    .C(C), .R(R), .D(D), .M(M), .SIR(SIR), .SIL(SIL),
`ifdef DFF_UREG_ROTATE_EN
    .ROT(rot),
`endif
    .Q(qa), .nQ(nqa), .SO(soa), .Z(za));
  dff_ureg #(.WIDTH(W), .INIT(8'h3C)) dut_b (
    .C(C), .R(R), .D(D), .M(M), .SIR(SIR), .SIL(SIL),
`ifdef DFF_UREG_ROTATE_EN
    .ROT(rot),
`endif
    .Q(qb), .nQ(nqb), .SO(sob), .Z(zb));

  always #5 C = ~C;

  function automatic logic [64:0] nxt(input logic [63:0] q, input logic [63:0] init);
    logic rin, lin;
    rin = (ROT_ON && rot) ? q[0] : SIR;
    lin = (ROT_ON && rot) ? q[W-1] : SIL;
    if (R === 1'b1) return {1'b0, init};
    if (M === 2'b01) return {q[0], (q >> 1) | (64'(rin) << (W-1))};
    if (M === 2'b10) return {q[W-1], ((q << 1) | 64'(lin)) & MASK};
    if (M === 2'b11) return {1'b0, 64'(D)};
    return {1'b0, q};
  endfunction

  always @(posedge C) begin
    {msa, ma} = nxt(ma, 64'h00);
    {msb, mb} = nxt(mb, 64'h3C);
    if (R === 1'b1) started = 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge C) if (started) begin
    chk("a_q", 64'(qa), ma);
    chk("a_nq", 64'(nqa), ~ma & MASK);
    chk("a_so", 64'(soa), 64'(msa));
    chk("a_z", 64'(za), 64'(ma == 0));
    chk("b_q", 64'(qb), mb);
    chk("b_nq", 64'(nqb), ~mb & MASK);
    chk("b_so", 64'(sob), 64'(msb));
    chk("b_z", 64'(zb), 64'(mb == 0));
  end

  task automatic step(input logic r, input logic [1:0] m, input logic [W-1:0] d,
                      input logic sr, input logic sl);
    R = r; M = m; D = d; SIR = sr; SIL = sl;
    @(posedge C);
    #1;
  endtask

  initial begin
    step(1, 2'b11, 8'hFF, 0, 0);
    chk("rst_q", 64'(qa), 64'h00);
    chk("rst_nq", 64'(nqa), 64'hFF);
    chk("rst_z", 64'(za), 64'd1);
    chk("rst_so", 64'(soa), 64'd0);
    chk("rst_b_q", 64'(qb), 64'h3C);
    step(0, 2'b11, 8'hA5, 0, 0);
    chk("load_q", 64'(qa), 64'hA5);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b00, 8'h00, 1, 1);
      chk("hold_q", 64'(qa), 64'hA5);
      chk("hold_nq", 64'(nqa), 64'h5A);
      chk("hold_z", 64'(za), 64'd0);
      chk("hold_so", 64'(soa), 64'd0);
    end
    step(0, 2'b01, 8'h00, 1, 1);
    chk("shr_q", 64'(qa), 64'hD2);
    chk("shr_so", 64'(soa), 64'd1);
    step(0, 2'b10, 8'h00, 1, 0);
    chk("shl_q", 64'(qa), 64'hA4);
    chk("shl_so", 64'(soa), 64'd1);
    step(0, 2'b11, 8'h01, 0, 0);
    step(0, 2'b01, 8'h00, 0, 0);
    chk("shr0_q", 64'(qa), 64'h00);
    chk("shr0_z", 64'(za), 64'd1);
    chk("shr0_so", 64'(soa), 64'd1);
    step(0, 2'b11, 8'hFF, 0, 0);
    step(0, 2'b10, 8'h00, 0, 0);
    step(0, 2'b10, 8'h00, 0, 0);
    chk("b_shl2", 64'(qb), 64'hFC);
    step(1, 2'b10, 8'h00, 0, 0);
    chk("b_rst_q", 64'(qb), 64'h3C);
    chk("b_rst_so", 64'(sob), 64'd0);
    step(0, 2'b01, 8'h00, 0, 0);
    chk("b_post_q", 64'(qb), 64'h1E);
`ifdef DFF_UREG_ROTATE_EN
    step(0, 2'b11, 8'h81, 0, 0);
    rot = 1;
    step(0, 2'b10, 8'h00, 0, 0);
    chk("rotl_q", 64'(qa), 64'h03);
    chk("rotl_so", 64'(soa), 64'd1);
    rot = 0;
    step(0, 2'b01, 8'h00, 0, 0);
    chk("shr_q2", 64'(qa), 64'h01);
    chk("shr_so2", 64'(soa), 64'd1);
`endif
    step(0, 2'b11, 8'h6B, 0, 0);
    step(0, 2'bxx, 8'h00, 1, 1);
    chk("mx_q", 64'(qa), 64'h6B);
    for (int i = 0; i < 400; i++) begin
      if (ROT_ON) rot = 1'($urandom_range(1));
      step(($urandom_range(15) == 0), 2'($urandom_range(3)), 8'($urandom),
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    @(negedge C);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
